// File: rtl/video_timing_pkg.sv
//------------------------------------------------------------------------------
// video_timing_pkg -- raster presets, FSM encoding and parameter check. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package video_timing_pkg;

  // CEA 1280x720p60 @ 74.25 MHz
  localparam int c_h_active_720 = 1280;
  localparam int c_h_fp_720     = 110;
  localparam int c_h_sync_720   = 40;
  localparam int c_h_bp_720     = 220;
  localparam int c_v_active_720 = 720;
  localparam int c_v_fp_720     = 5;
  localparam int c_v_sync_720   = 5;
  localparam int c_v_bp_720     = 20;
  localparam int c_h_total_720  = c_h_active_720 + c_h_fp_720 + c_h_sync_720 + c_h_bp_720;
  localparam int c_v_total_720  = c_v_active_720 + c_v_fp_720 + c_v_sync_720 + c_v_bp_720;

  // CEA 1920x1080p30 @ 74.25 MHz
  localparam int c_h_active_1080 = 1920;
  localparam int c_h_fp_1080     = 88;
  localparam int c_h_sync_1080   = 44;
  localparam int c_h_bp_1080     = 148;
  localparam int c_v_active_1080 = 1080;
  localparam int c_v_fp_1080     = 4;
  localparam int c_v_sync_1080   = 5;
  localparam int c_v_bp_1080     = 36;
  localparam int c_h_total_1080  = c_h_active_1080 + c_h_fp_1080 + c_h_sync_1080 + c_h_bp_1080;
  localparam int c_v_total_1080  = c_v_active_1080 + c_v_fp_1080 + c_v_sync_1080 + c_v_bp_1080;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  // Every interval of a raster axis must be at least one unit long.
  function automatic bit timing_params_legal(input int act, input int fp,
                                             input int sync, input int bp);
    return (act > 0) && (fp > 0) && (sync > 0) && (bp > 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_if.sv
//------------------------------------------------------------------------------
// video_timing_if -- run request in, raster timing and status out. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface video_timing_if #(
  parameter int CNT_W = 12
);
  logic             gen_en;
  logic             fsync;
  logic             active_video;
  logic             hsync;
  logic             vsync;
  logic             running;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic [15:0]      frame_count;

  modport master (
    input  gen_en,
    output fsync, active_video, hsync, vsync, running,
    output h_count, v_count, frame_count
  );

  modport slave (
    output gen_en,
    input  fsync, active_video, hsync, vsync, running,
    input  h_count, v_count, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/video_axis_counter.sv
//------------------------------------------------------------------------------
// video_axis_counter -- modulo-MODULUS position counter with terminal count. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module video_axis_counter #(
  parameter int MODULUS = 1650,
  parameter int CNT_W   = 12
) (
  input  wire logic             video_clk,
  input  wire logic             resetn,
  input  wire logic             clr_i,
  input  wire logic             inc_en_i,
  output logic      [CNT_W-1:0] count_o,
  output logic                  tc_o
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o    = (count_q == c_last);
  assign count_o = count_q;

  // Clear has priority so the parent can park the counter while idle.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge video_clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
//------------------------------------------------------------------------------
// video_timing_gen -- free-running raster timing generator (fsync/DE/hsync/vsync). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = c_h_active_720,
  parameter int H_FP      = c_h_fp_720,
  parameter int H_SYNC    = c_h_sync_720,
  parameter int H_BP      = c_h_bp_720,
  parameter int V_ACTIVE  = c_v_active_720,
  parameter int V_FP      = c_v_fp_720,
  parameter int V_SYNC    = c_v_sync_720,
  parameter int V_BP      = c_v_bp_720,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 12
) (
  input wire logic       video_clk,
  input wire logic       resetn,
  video_timing_if.master vif
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_act      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_v_act      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (!timing_params_legal(H_ACTIVE, H_FP, H_SYNC, H_BP) ||
      !timing_params_legal(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_illegal_params
    $error("video_timing_gen: every H_* and V_* timing parameter must be non-zero");
  end

  if ((c_h_total > (1 << CNT_W)) || (c_v_total > (1 << CNT_W))) begin : g_cnt_w_too_small
    $error("video_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end

  gen_state_e       state_q, state_d;
  logic             stop_pending_q, stop_pending_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic             fsync_q, active_video_q, hsync_q, vsync_q, running_q;
  logic [CNT_W-1:0] h_count_q, v_count_q;

  logic             w_run;
  logic [CNT_W-1:0] w_h, w_v;
  logic             w_h_tc, w_v_tc;
  logic             w_frame_wrap;
  logic             w_act, w_hs, w_vs, w_fs;

  assign w_run        = (state_q == ST_RUN);
  assign w_frame_wrap = w_run && w_h_tc && w_v_tc;

  video_axis_counter #(
    .MODULUS (c_h_total),
    .CNT_W   (CNT_W)
  ) u_h_cnt (
    .video_clk (video_clk),
    .resetn    (resetn),
    .clr_i     (!w_run),
    .inc_en_i  (w_run),
    .count_o   (w_h),
    .tc_o      (w_h_tc)
  );

  video_axis_counter #(
    .MODULUS (c_v_total),
    .CNT_W   (CNT_W)
  ) u_v_cnt (
    .video_clk (video_clk),
    .resetn    (resetn),
    .clr_i     (!w_run),
    .inc_en_i  (w_run && w_h_tc),
    .count_o   (w_v),
    .tc_o      (w_v_tc)
  );

  // A stop request only takes effect at the frame wrap, so frames are never cut short.
  always_comb begin
    state_d        = state_q;
    stop_pending_d = 1'b0;
    frame_count_d  = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (vif.gen_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        stop_pending_d = !vif.gen_en;
        if (w_frame_wrap) begin
          frame_count_d = frame_count_q + 16'd1;
          if (stop_pending_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge video_clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      stop_pending_q <= 1'b0;
      frame_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
      frame_count_q  <= frame_count_d;
    end
  end

  always_comb begin
    w_act = (w_h < c_h_act) && (w_v < c_v_act);
    w_hs  = (w_h >= c_hs_start) && (w_h < c_hs_end);
    w_vs  = (w_v >= c_vs_start) && (w_v < c_vs_end);
    w_fs  = (w_h == '0) && (w_v == '0);
  end

  // All outputs share one register stage so position and timing stay aligned.
  always_ff @(posedge video_clk) begin
    if (!resetn) begin
      fsync_q        <= 1'b0;
      active_video_q <= 1'b0;
      hsync_q        <= ~HSYNC_POL;
      vsync_q        <= ~VSYNC_POL;
      running_q      <= 1'b0;
      h_count_q      <= '0;
      v_count_q      <= '0;
    end else begin
      fsync_q        <= w_run && w_fs;
      active_video_q <= w_run && w_act;
      hsync_q        <= (w_run && w_hs) ~^ HSYNC_POL;
      vsync_q        <= (w_run && w_vs) ~^ VSYNC_POL;
      running_q      <= w_run;
      h_count_q      <= w_h;
      v_count_q      <= w_v;
    end
  end

  assign vif.fsync        = fsync_q;
  assign vif.active_video = active_video_q;
  assign vif.hsync        = hsync_q;
  assign vif.vsync        = vsync_q;
  assign vif.running      = running_q;
  assign vif.h_count      = h_count_q;
  assign vif.v_count      = v_count_q;
  assign vif.frame_count  = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
//------------------------------------------------------------------------------
// tb_video_timing_gen -- small-raster directed bench with a position-based reference model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int FRAME = HT * VT;          // 98

  logic video_clk = 1'b0;
  logic resetn    = 1'b0;
  logic gen_en    = 1'b0;

  always #5 video_clk = ~video_clk;

  video_timing_if #(.CNT_W(12)) ifa ();
  video_timing_if #(.CNT_W(12)) ifb ();
  assign ifa.gen_en = gen_en;
  assign ifb.gen_en = gen_en;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(12)
  ) dut_a (
    .video_clk (video_clk),
    .resetn    (resetn),
    .vif       (ifa.master)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(12)
  ) dut_b (
    .video_clk (video_clk),
    .resetn    (resetn),
    .vif       (ifb.master)
  );

  int total = 0;
  int bad   = 0;

  // Reference: a single position p inside a FRAME-long raster, h = p % HT, v = p / HT.
  int          m_p    = 0;
  bit          m_run  = 1'b0;
  bit          m_stop = 1'b0;
  logic [15:0] m_fc   = 16'd0;
  int          preload_seq = 0;
  int          seen_seq    = 0;
  logic [15:0] preload_val = 16'd0;

  bit          e_valid = 1'b0;
  bit          e_fs, e_act, e_hs, e_vs, e_run;
  int          e_h, e_v;
  logic [15:0] e_fc;

  always @(posedge video_clk) begin
    int h, v;
    if (preload_seq != seen_seq) begin
      seen_seq = preload_seq;
      m_fc     = preload_val;
    end
    if (!resetn) begin
      m_run = 1'b0; m_p = 0; m_stop = 1'b0; m_fc = 16'd0;
      e_fs = 1'b0; e_act = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_run = 1'b0;
      e_h = 0; e_v = 0;
    end else begin
      h = m_p % HT;
      v = m_p / HT;
      e_run = m_run;
      e_fs  = m_run && (m_p == 0);
      e_act = m_run && (h < HA) && (v < VA);
      e_hs  = m_run && (h >= HA + HF) && (h < HA + HF + HS);
      e_vs  = m_run && (v >= VA + VF) && (v < VA + VF + VS);
      e_h   = h;
      e_v   = v;
      if (m_run) begin
        if (m_p == FRAME - 1) begin
          m_fc = m_fc + 16'd1;
          m_p  = 0;
          if (m_stop) m_run = 1'b0;
        end else begin
          m_p = m_p + 1;
        end
        m_stop = !gen_en;
      end else begin
        m_stop = 1'b0;
        if (gen_en) m_run = 1'b1;
      end
    end
    e_fc    = m_fc;
    e_valid = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    if (e_valid) begin
      chk("fsync_a",  int'(ifa.fsync),        int'(e_fs));
      chk("active_a", int'(ifa.active_video), int'(e_act));
      chk("hsync_a",  int'(ifa.hsync),        int'(e_hs));
      chk("vsync_a",  int'(ifa.vsync),        int'(e_vs));
      chk("running_a",int'(ifa.running),      int'(e_run));
      chk("h_count_a",int'(ifa.h_count),      e_h);
      chk("v_count_a",int'(ifa.v_count),      e_v);
      chk("fcount_a", int'(ifa.frame_count),  int'(e_fc));
      chk("fsync_b",  int'(ifb.fsync),        int'(e_fs));
      chk("hsync_b",  int'(ifb.hsync),        int'(!e_hs));
      chk("vsync_b",  int'(ifb.vsync),        int'(!e_vs));
      chk("fcount_b", int'(ifb.frame_count),  int'(e_fc));
    end
  endtask

  task automatic step();
    @(negedge video_clk);
    cmp_all();
  endtask

  task automatic wait_fsync(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (ifa.fsync) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_pos(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (ifa.running && ifa.h_count == 12'(h) && ifa.v_count == 12'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called with fsync visible; accumulates one frame and stops on the next fsync.
  task automatic measure_frame(output int period, output int n_act, output int n_hs,
                               output int hs_bad, output int n_vs, output int vs_first_v,
                               output int n_hsb_low);
    period = 0; n_act = 0; n_hs = 0; hs_bad = 0; n_vs = 0; vs_first_v = -1; n_hsb_low = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (ifa.active_video) n_act++;
      if (ifa.hsync) n_hs++;
      if (ifa.hsync != (ifa.h_count >= 12'd10 && ifa.h_count <= 12'd11)) hs_bad++;
      if (!ifb.hsync) n_hsb_low++;
      if (ifa.vsync) begin
        n_vs++;
        if (vs_first_v < 0) vs_first_v = int'(ifa.v_count);
      end
      step();
      period++;
      if (ifa.fsync) break;
    end
  endtask

  initial begin
    int n, period, n_act, n_hs, hs_bad, n_vs, vs_first_v, n_hsb_low, runs_low, fs_seen;
    bit ok;
    logic [15:0] fc0;

    resetn = 1'b0;
    gen_en = 1'b0;
    repeat (3) step();
    chk("reset_hsync_a", int'(ifa.hsync), 0);
    chk("reset_hsync_b_level", int'(ifb.hsync), 1);
    chk("reset_vsync_b_level", int'(ifb.vsync), 1);
    chk("reset_frame_count", int'(ifa.frame_count), 0);

    resetn = 1'b1;
    repeat (4) step();
    chk("idle_running", int'(ifa.running), 0);
    chk("idle_hsync_b_level", int'(ifb.hsync), 1);

    // Start: fsync two cycles after gen_en is sampled
    gen_en = 1'b1;
    wait_fsync(20, n);
    chk("start_latency", n, 2);

    measure_frame(period, n_act, n_hs, hs_bad, n_vs, vs_first_v, n_hsb_low);
    chk("fsync_period", period, 98);
    chk("active_cycles", n_act, 32);
    chk("hsync_cycles", n_hs, 14);
    chk("hsync_at_h10_11", hs_bad, 0);
    chk("hsync_b_low_cycles", n_hsb_low, 14);
    chk("vsync_cycles", n_vs, 14);
    chk("vsync_first_line", vs_first_v, 5);
    measure_frame(period, n_act, n_hs, hs_bad, n_vs, vs_first_v, n_hsb_low);
    chk("fsync_period_2", period, 98);
    chk("frame_count_after_2", int'(ifa.frame_count), 2);

    // Drop gen_en mid-frame: frame completes, then idle
    wait_pos(3, 1, ok);
    chk("reach_h3_v1", int'(ok), 1);
    fc0 = ifa.frame_count;
    gen_en = 1'b0;
    n = -1;
    fs_seen = 0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      step();
      if (ifa.fsync) fs_seen++;
      if (!ifa.running) begin
        n = i;
        break;
      end
    end
    chk("stop_after_wrap", n, 81);
    chk("stop_no_fsync", fs_seen, 0);
    chk("stop_fc_plus1", int'(ifa.frame_count), int'(fc0 + 16'd1));
    fs_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ifa.fsync) fs_seen++;
    end
    chk("idle_no_fsync", fs_seen, 0);
    chk("idle_fc_hold", int'(ifa.frame_count), int'(fc0 + 16'd1));

    // Restart, then drop and reassert before the wrap: no gap
    gen_en = 1'b1;
    wait_fsync(20, n);
    chk("restart_latency", n, 2);
    wait_pos(3, 1, ok);
    chk("reach_h3_v1_again", int'(ok), 1);
    gen_en = 1'b0;
    runs_low = 0;
    repeat (5) begin
      step();
      if (!ifa.running) runs_low++;
    end
    gen_en = 1'b1;
    n = 5;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      n++;
      if (!ifa.running) runs_low++;
      if (ifa.fsync) break;
    end
    chk("reassert_next_fsync", n, 81);
    chk("reassert_running_gap", runs_low, 0);

    // Reset mid-line
    wait_pos(5, 2, ok);
    chk("reach_h5_v2", int'(ok), 1);
    resetn = 1'b0;
    step();
    chk("midrst_fsync", int'(ifa.fsync), 0);
    chk("midrst_active", int'(ifa.active_video), 0);
    chk("midrst_hsync_b", int'(ifb.hsync), 1);
    chk("midrst_running", int'(ifa.running), 0);
    chk("midrst_h_count", int'(ifa.h_count), 0);
    chk("midrst_v_count", int'(ifa.v_count), 0);
    chk("midrst_frame_count", int'(ifa.frame_count), 0);
    resetn = 1'b1;
    wait_fsync(20, n);
    chk("post_reset_latency", n, 2);

    // frame_count rollover from a preloaded value
    wait_pos(2, 0, ok);
    chk("reach_h2_v0", int'(ok), 1);
    preload_val = 16'hFFFE;
    preload_seq++;
    force dut_a.frame_count_q = 16'hFFFE;
    force dut_b.frame_count_q = 16'hFFFE;
    #1;
    release dut_a.frame_count_q;
    release dut_b.frame_count_q;
    wait_fsync(2 * FRAME, n);
    chk("preload_fc_ffff", int'(ifa.frame_count), 32'h0000FFFF);
    wait_fsync(2 * FRAME, n);
    chk("rollover_period", n, 98);
    chk("rollover_fc_zero", int'(ifa.frame_count), 0);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
